pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 143 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Power-up reset sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the SDRAM controller and core resets in order. Define PLL_RESET_SEQ_TIMEOUT_EN to retry
// the PLL reset when lock does not arrive within LOCK_TIMEOUT cycles.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  output logic       pll_rst,
  output logic       sdram_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                 : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_SDRAM_INIT,
    S_RUN
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lock_sync, done_sync;
  logic             lock_s, done_s;
  logic             lost;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  logic             timeout_hit;
  logic [3:0]       retry_q;
`endif

  // Both status inputs come from other clock domains.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync <= 2'b00;
      done_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
      done_sync <= {done_sync[0], sdram_init_done};
    end
  end

  assign lock_s = lock_sync[1];
  assign done_s = done_sync[1];

  // Lock loss outranks counter/done completion; only a loss after SDRAM release is reported.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
    state_next = state;
    lost       = 1'b0;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      S_PLL_RESET: begin
        if (cnt == PLL_RST_LAST) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = S_STABLE;
        end
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) begin
          state_next  = S_PLL_RESET;
          timeout_hit = 1'b1;
        end
`endif
      end
      S_STABLE: begin
        if (!lock_s)                 state_next = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_next = S_SDRAM_INIT;
      end
      S_SDRAM_INIT: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          lost       = 1'b1;
        end else if (done_s) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          lost       = 1'b1;
        end
      end
      default: state_next = S_PLL_RESET;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PLL_RESET;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sdram_rst <= 1'b1;
      core_rst  <= 1'b1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + CNT_W'(1);
      pll_rst   <= (state_next == S_PLL_RESET);
      sdram_rst <= !(state_next inside {S_SDRAM_INIT, S_RUN});
      core_rst  <= (state_next != S_RUN);
      ready     <= (state_next == S_RUN);
      lock_lost <= lost;
    end
  end

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)                                retry_q <= 4'd0;
    else if (timeout_hit && retry_q != 4'hF) retry_q <= retry_q + 4'd1;
  end

  assign retry_count = retry_q;
`else
  assign retry_count = 4'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8,
// LOCK_TIMEOUT=32. Edge numbers in comments count rising edges from the last rst edge (E0).
module tb_pll_reset_sequencer;

  localparam int PLL_RST_CYCLES     = 4;
  localparam int LOCK_STABLE_CYCLES = 8;
  localparam int LOCK_TIMEOUT       = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sdram_init_done = 1'b0;
  logic       pll_rst, sdram_rst, core_rst, ready, lock_lost;
  logic [3:0] retry_count;

  int errors = 0;
  int checks = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES    (PLL_RST_CYCLES),
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
    .LOCK_TIMEOUT      (LOCK_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .sdram_init_done(sdram_init_done),
    .pll_rst        (pll_rst),
    .sdram_rst      (sdram_rst),
    .core_rst       (core_rst),
    .ready          (ready),
    .lock_lost      (lock_lost),
    .retry_count    (retry_count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b1; sdram_init_done = 1'b0;
    step();
    checks++; if (pll_rst !== 1'b1)     begin errors++; $display("FAIL reset_pll_rst got=%b want=1", pll_rst); end
    checks++; if (sdram_rst !== 1'b1)   begin errors++; $display("FAIL reset_sdram_rst got=%b want=1", sdram_rst); end
    checks++; if (core_rst !== 1'b1)    begin errors++; $display("FAIL reset_core_rst got=%b want=1", core_rst); end
    checks++; if (ready !== 1'b0)       begin errors++; $display("FAIL reset_ready got=%b want=0", ready); end
    checks++; if (lock_lost !== 1'b0)   begin errors++; $display("FAIL reset_lock_lost got=%b want=0", lock_lost); end
    checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL reset_retry got=%0d want=0", retry_count); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL held_rst_pll_rst cycle=%0d got=%b want=1", i, pll_rst); end
    end
  endtask

  task automatic test_bringup();
    int n;
    rst = 1'b0;                         // last rst edge was E0
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pll_rst !== 1'b1) break;
      n++;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL bringup_pll_rst_width got=%0d want=4", n); end
    // E4 WAIT_LOCK, E5..E12 STABLE, sdram_rst falls at E13.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(); n++;
      if (sdram_rst === 1'b0) break;
    end
    checks++; if (n != 9) begin errors++; $display("FAIL bringup_sdram_release got=%0d want=9 edges after E4", n); end
    checks++; if (core_rst !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL bringup_sdram_init_outs core_rst=%b ready=%b want 1/0", core_rst, ready); end
    step(5);                             // E18
    sdram_init_done = 1'b1;
    step(2);                             // E20: done_s only now high
    checks++; if (core_rst !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL bringup_early_run core_rst=%b ready=%b want 1/0", core_rst, ready); end
    step();                              // E21
    checks++; if (core_rst !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL bringup_run core_rst=%b ready=%b want 0/1", core_rst, ready); end
    checks++; if (sdram_rst !== 1'b0 || pll_rst !== 1'b0) begin errors++; $display("FAIL bringup_run_resets sdram_rst=%b pll_rst=%b want 0/0", sdram_rst, pll_rst); end
  endtask

  task automatic test_lock_loss();
    int lost, fall, rise;
    pll_locked = 1'b0;                   // Ea
    step(2);
    checks++; if (ready !== 1'b1 || lock_lost !== 1'b0) begin errors++; $display("FAIL loss_sync_latency ready=%b lock_lost=%b want 1/0", ready, lock_lost); end
    step();                              // Ea+3
    checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL loss_pulse got=%b want=1", lock_lost); end
    checks++; if (ready !== 1'b0 || sdram_rst !== 1'b1 || core_rst !== 1'b1) begin errors++; $display("FAIL loss_resets ready=%b sdram_rst=%b core_rst=%b want 0/1/1", ready, sdram_rst, core_rst); end
    pll_locked = 1'b1;
    // lock_s back at Ea+5, STABLE Ea+6..Ea+13, SDRAM_INIT Ea+14, RUN Ea+15 (done still high).
    lost = 0; fall = -1; rise = -1;
    for (int c = 4; c <= 20; c++) begin
      step();
      if (lock_lost === 1'b1) lost++;
      if (sdram_rst === 1'b0 && fall < 0) fall = c;
      if (ready === 1'b1 && rise < 0) rise = c;
    end
    checks++; if (lost != 0)  begin errors++; $display("FAIL loss_extra_pulses got=%0d want=0", lost); end
    checks++; if (fall != 14) begin errors++; $display("FAIL loss_sdram_release got=%0d want=14", fall); end
    checks++; if (rise != 15) begin errors++; $display("FAIL loss_ready_return got=%0d want=15", rise); end
  endtask

  task automatic test_glitch_in_stable();
    int lost, fall;
    sdram_init_done = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;      // E0
    step(9);                             // E9
    pll_locked = 1'b0;
    step();                              // E10
    pll_locked = 1'b1;
    // lock_s low while STABLE cnt=6 (after E11) -> WAIT_LOCK E12, STABLE E13..E20, release E21.
    lost = 0; fall = -1;
    for (int c = 11; c <= 30; c++) begin
      step();
      if (lock_lost === 1'b1) lost++;
      if (sdram_rst === 1'b0) begin fall = c; break; end
    end
    checks++; if (lost != 0)  begin errors++; $display("FAIL glitch_lock_lost got=%0d want=0", lost); end
    checks++; if (fall != 21) begin errors++; $display("FAIL glitch_sdram_release got=%0d want=21", fall); end
  endtask

  task automatic test_rst_in_sdram_init();
    int n;
    sdram_init_done = 1'b1;              // E21, in SDRAM_INIT
    step(2);                             // E23: done_s high this cycle
    checks++; if (sdram_rst !== 1'b0 || core_rst !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL rstinit_pre sdram_rst=%b core_rst=%b ready=%b want 0/1/0", sdram_rst, core_rst, ready); end
    rst = 1'b1;
    step();
    checks++; if (pll_rst !== 1'b1)     begin errors++; $display("FAIL rstinit_pll_rst got=%b want=1", pll_rst); end
    checks++; if (sdram_rst !== 1'b1)   begin errors++; $display("FAIL rstinit_sdram_rst got=%b want=1", sdram_rst); end
    checks++; if (core_rst !== 1'b1)    begin errors++; $display("FAIL rstinit_core_rst got=%b want=1", core_rst); end
    checks++; if (ready !== 1'b0)       begin errors++; $display("FAIL rstinit_ready got=%b want=0", ready); end
    checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL rstinit_retry got=%0d want=0", retry_count); end
    rst = 1'b0;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pll_rst !== 1'b1) break;
      n++;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL restart_pll_rst_width got=%0d want=4", n); end
    // done stays high throughout but must be ignored until SDRAM_INIT (E13); RUN follows at E14.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(); n++;
      if (sdram_rst === 1'b0) break;
    end
    checks++; if (n != 9 || ready !== 1'b0) begin errors++; $display("FAIL restart_sdram_release edges=%0d ready=%b want 9/0", n, ready); end
    step();
    checks++; if (ready !== 1'b1 || core_rst !== 1'b0) begin errors++; $display("FAIL restart_run ready=%b core_rst=%b want 1/0", ready, core_rst); end
  endtask

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int bad_pll, bad_retry, exp_retry;
    logic exp_pll;
    sdram_init_done = 1'b0; pll_locked = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;      // E0
    bad_pll = 0; bad_retry = 0;
    // 4 cycles PLL_RESET + 32 WAIT_LOCK: pll_rst high for edges c with c%36 < 4.
    for (int c = 1; c <= 620; c++) begin
      step();
      exp_pll   = ((c % 36) < 4);
      exp_retry = (c / 36 > 15) ? 15 : c / 36;
      if (pll_rst !== exp_pll) begin
        if (bad_pll == 0) $display("FAIL timeout_pll_rst edge=%0d got=%b want=%b", c, pll_rst, exp_pll);
        bad_pll++;
      end
      if (retry_count !== 4'(exp_retry)) begin
        if (bad_retry == 0) $display("FAIL timeout_retry edge=%0d got=%0d want=%0d", c, retry_count, exp_retry);
        bad_retry++;
      end
    end
    checks++; if (bad_pll != 0)   errors++;
    checks++; if (bad_retry != 0) errors++;
    checks++; if (retry_count !== 4'd15) begin errors++; $display("FAIL timeout_saturate got=%0d want=15", retry_count); end
  endtask
`else
  task automatic test_no_timeout();
    int hi, bad_retry, bad_sdram, n;
    sdram_init_done = 1'b0; pll_locked = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;      // E0
    hi = 0; bad_retry = 0; bad_sdram = 0;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (c >= 4 && pll_rst !== 1'b0) hi++;
      if (retry_count !== 4'd0) bad_retry++;
      if (sdram_rst !== 1'b1) bad_sdram++;
    end
    checks++; if (hi != 0)        begin errors++; $display("FAIL notimeout_pll_rst high_cycles=%0d want=0", hi); end
    checks++; if (bad_retry != 0) begin errors++; $display("FAIL notimeout_retry bad_cycles=%0d want=0", bad_retry); end
    checks++; if (bad_sdram != 0) begin errors++; $display("FAIL notimeout_sdram_rst low_cycles=%0d want=0", bad_sdram); end
    // Still in WAIT_LOCK: lock_s after 2 edges, STABLE 8 edges, release on the 11th.
    pll_locked = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(); n++;
      if (sdram_rst === 1'b0) break;
    end
    checks++; if (n != 11) begin errors++; $display("FAIL notimeout_late_lock edges=%0d want=11", n); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_glitch_in_stable();
    test_rst_in_sdram_init();
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
